// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and loads the IF/ID register.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module pc_fetch_unit #(
    parameter int ADDR_W = 64,
    parameter int INST_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              halt_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0] ifid_pc,
    output logic [INST_W-1:0] ifid_inst,
    output logic              ifid_valid,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_bubbles,
`endif
    output logic              halted
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              load_normal;
    logic              load_bubble;

    assign imem_addr = pc;

    // Classify this cycle's IF/ID update; shared by the pipeline register and the counters.
    always_comb begin
        load_normal = 1'b0;
        load_bubble = 1'b0;
        case (state)
            BOOT: load_bubble = 1'b1;
            RUN: begin
                if (br_taken || halt_req)
                    load_bubble = 1'b1;
                else if (!stall)
                    load_normal = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            ifid_pc    <= '0;
            ifid_inst  <= '0;
            ifid_valid <= 1'b0;
            halted     <= 1'b0;
        end else begin
            if (load_bubble)
                ifid_valid <= 1'b0;
            if (load_normal) begin
                ifid_pc    <= pc;
                ifid_inst  <= imem_rdata;
                ifid_valid <= 1'b1;
                pc         <= pc + ADDR_W'(4);
            end
            case (state)
                BOOT: begin
                    state  <= halt_req ? HALT : RUN;
                    halted <= halt_req;
                end
                RUN: begin
                    if (br_taken) begin
                        pc <= {br_target[ADDR_W-1:2], 2'b00};
                    end else if (halt_req) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end
                end
                HALT: halted <= 1'b1;
                default: state <= BOOT;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating event counters; nothing is classified in HALT so they hold there.
    always_ff @(posedge clk) begin
        if (Reset) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (load_normal && perf_fetched != 32'hFFFF_FFFF)
                perf_fetched <= perf_fetched + 32'd1;
            if (load_bubble && perf_bubbles != 32'hFFFF_FFFF)
                perf_bubbles <= perf_bubbles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit with RESET_PC=0x100.
// Memory model returns 0xAA000000 + low 32 address bits.
module tb_pc_fetch_unit;

    localparam int ADDR_W = 64;
    localparam int INST_W = 32;
    localparam logic [63:0] RPC = 64'h100;

    logic              clk = 1'b0;
    logic              Reset;
    logic              stall;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic              halt_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_rdata;
    logic [ADDR_W-1:0] ifid_pc;
    logic [INST_W-1:0] ifid_inst;
    logic              ifid_valid;
    logic              halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]       perf_fetched;
    logic [31:0]       perf_bubbles;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign imem_rdata = 32'hAA00_0000 + imem_addr[31:0];

    pc_fetch_unit #(.ADDR_W(ADDR_W), .INST_W(INST_W), .RESET_PC(RPC)) dut (
        .clk(clk),
        .Reset(Reset),
        .stall(stall),
        .br_taken(br_taken),
        .br_target(br_target),
        .halt_req(halt_req),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .ifid_pc(ifid_pc),
        .ifid_inst(ifid_inst),
        .ifid_valid(ifid_valid),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched(perf_fetched),
        .perf_bubbles(perf_bubbles),
`endif
        .halted(halted)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall     = 1'b0;
        br_taken  = 1'b0;
        br_target = '0;
        halt_req  = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        idle_inputs();
        step();
        step();
        total++; if (ifid_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%0b exp=0", ifid_valid); end
        total++; if (ifid_pc !== 64'h0) begin bad++; $display("[TB] FAIL reset_ifid_pc got=%h exp=0", ifid_pc); end
        total++; if (ifid_inst !== 32'h0) begin bad++; $display("[TB] FAIL reset_ifid_inst got=%h exp=0", ifid_inst); end
        total++; if (halted !== 1'b0) begin bad++; $display("[TB] FAIL reset_halted got=%0b exp=0", halted); end
        total++; if (imem_addr !== 64'h100) begin bad++; $display("[TB] FAIL reset_addr got=%h exp=100", imem_addr); end
        Reset = 1'b0;
        step();
        total++; if (ifid_valid !== 1'b0) begin bad++; $display("[TB] FAIL boot_valid got=%0b exp=0", ifid_valid); end
        total++; if (imem_addr !== 64'h100) begin bad++; $display("[TB] FAIL boot_addr got=%h exp=100", imem_addr); end
        step();
        total++; if (ifid_valid !== 1'b1) begin bad++; $display("[TB] FAIL c2_valid got=%0b exp=1", ifid_valid); end
        total++; if (ifid_pc !== 64'h100) begin bad++; $display("[TB] FAIL c2_pc got=%h exp=100", ifid_pc); end
        total++; if (ifid_inst !== 32'hAA00_0100) begin bad++; $display("[TB] FAIL c2_inst got=%h exp=aa000100", ifid_inst); end
        step();
        total++; if (ifid_pc !== 64'h104) begin bad++; $display("[TB] FAIL c3_pc got=%h exp=104", ifid_pc); end
        total++; if (imem_addr !== 64'h108) begin bad++; $display("[TB] FAIL c3_addr got=%h exp=108", imem_addr); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (ifid_pc !== 64'h104 || ifid_valid !== 1'b1 || ifid_inst !== 32'hAA00_0104)
                begin bad++; $display("[TB] FAIL stall_hold[%0d] got pc=%h v=%0b inst=%h exp pc=104 v=1 inst=aa000104", i, ifid_pc, ifid_valid, ifid_inst); end
            total++; if (imem_addr !== 64'h108) begin bad++; $display("[TB] FAIL stall_addr[%0d] got=%h exp=108", i, imem_addr); end
        end
        stall = 1'b0;
        step();
        total++; if (ifid_pc !== 64'h108 || ifid_inst !== 32'hAA00_0108)
            begin bad++; $display("[TB] FAIL stall_resume got pc=%h inst=%h exp pc=108 inst=aa000108", ifid_pc, ifid_inst); end
        total++; if (imem_addr !== 64'h10C) begin bad++; $display("[TB] FAIL stall_resume_addr got=%h exp=10c", imem_addr); end
    endtask

    task automatic test_redirect();
        br_taken  = 1'b1;
        br_target = 64'h2003;
        stall     = 1'b1;
        step();
        idle_inputs();
        total++; if (ifid_valid !== 1'b0) begin bad++; $display("[TB] FAIL redir_squash got=%0b exp=0", ifid_valid); end
        total++; if (imem_addr !== 64'h2000) begin bad++; $display("[TB] FAIL redir_addr got=%h exp=2000", imem_addr); end
        step();
        total++; if (ifid_pc !== 64'h2000 || ifid_valid !== 1'b1 || ifid_inst !== 32'hAA00_2000)
            begin bad++; $display("[TB] FAIL redir_fetch got pc=%h v=%0b inst=%h exp pc=2000 v=1 inst=aa002000", ifid_pc, ifid_valid, ifid_inst); end
    endtask

    task automatic test_wrap();
        br_taken  = 1'b1;
        br_target = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        idle_inputs();
        total++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("[TB] FAIL wrap_setup got=%h exp=fffffffffffffffc", imem_addr); end
        step();
        total++; if (imem_addr !== 64'h0) begin bad++; $display("[TB] FAIL wrap_addr got=%h exp=0", imem_addr); end
        total++; if (ifid_pc !== 64'hFFFF_FFFF_FFFF_FFFC || ifid_inst !== 32'hA9FF_FFFC || ifid_valid !== 1'b1)
            begin bad++; $display("[TB] FAIL wrap_ifid got pc=%h inst=%h v=%0b exp pc=fffffffffffffffc inst=a9fffffc v=1", ifid_pc, ifid_inst, ifid_valid); end
        step();
        total++; if (ifid_pc !== 64'h0 || imem_addr !== 64'h4) begin bad++; $display("[TB] FAIL wrap_next got pc=%h addr=%h exp pc=0 addr=4", ifid_pc, imem_addr); end
    endtask

    task automatic test_halt();
        br_taken  = 1'b1;
        br_target = 64'h120;
        step();
        idle_inputs();
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        total++; if (halted !== 1'b1 || ifid_valid !== 1'b0) begin bad++; $display("[TB] FAIL halt_enter got h=%0b v=%0b exp h=1 v=0", halted, ifid_valid); end
        total++; if (imem_addr !== 64'h120) begin bad++; $display("[TB] FAIL halt_addr got=%h exp=120", imem_addr); end
        br_taken  = 1'b1;
        br_target = 64'h4000;
        stall     = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (halted !== 1'b1 || ifid_valid !== 1'b0 || imem_addr !== 64'h120)
                begin bad++; $display("[TB] FAIL halt_hold[%0d] got h=%0b v=%0b addr=%h exp h=1 v=0 addr=120", i, halted, ifid_valid, imem_addr); end
        end
        idle_inputs();
        step();
        total++; if (halted !== 1'b1 || imem_addr !== 64'h120) begin bad++; $display("[TB] FAIL halt_idle got h=%0b addr=%h exp h=1 addr=120", halted, imem_addr); end
        Reset = 1'b1;
        br_taken = 1'b1;
        br_target = 64'h4000;
        step();
        idle_inputs();
        Reset = 1'b0;
        total++; if (halted !== 1'b0 || imem_addr !== 64'h100 || ifid_valid !== 1'b0)
            begin bad++; $display("[TB] FAIL halt_reset got h=%0b addr=%h v=%0b exp h=0 addr=100 v=0", halted, imem_addr, ifid_valid); end
        step();
        total++; if (ifid_valid !== 1'b0) begin bad++; $display("[TB] FAIL halt_reboot got=%0b exp=0", ifid_valid); end
        step();
        total++; if (ifid_pc !== 64'h100 || ifid_valid !== 1'b1) begin bad++; $display("[TB] FAIL halt_refetch got pc=%h v=%0b exp pc=100 v=1", ifid_pc, ifid_valid); end
    endtask

    task automatic test_boot_halt();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        halt_req = 1'b1;
        step();
        idle_inputs();
        total++; if (halted !== 1'b1 || ifid_valid !== 1'b0 || imem_addr !== 64'h100)
            begin bad++; $display("[TB] FAIL boot_halt got h=%0b v=%0b addr=%h exp h=1 v=0 addr=100", halted, ifid_valid, imem_addr); end
        step();
        total++; if (halted !== 1'b1 || imem_addr !== 64'h100) begin bad++; $display("[TB] FAIL boot_halt_hold got h=%0b addr=%h exp h=1 addr=100", halted, imem_addr); end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        Reset = 1'b1;
        idle_inputs();
        step();
        total++; if (perf_fetched !== 32'd0 || perf_bubbles !== 32'd0)
            begin bad++; $display("[TB] FAIL perf_reset got f=%0d b=%0d exp f=0 b=0", perf_fetched, perf_bubbles); end
        Reset = 1'b0;
        step();
        for (int i = 0; i < 10; i++) step();
        br_taken  = 1'b1;
        br_target = 64'h3000;
        step();
        idle_inputs();
        total++; if (perf_fetched !== 32'd10 || perf_bubbles !== 32'd2)
            begin bad++; $display("[TB] FAIL perf_count got f=%0d b=%0d exp f=10 b=2", perf_fetched, perf_bubbles); end
        halt_req = 1'b1;
        step();
        idle_inputs();
        step();
        step();
        total++; if (perf_fetched !== 32'd10 || perf_bubbles !== 32'd3)
            begin bad++; $display("[TB] FAIL perf_halt got f=%0d b=%0d exp f=10 b=3", perf_fetched, perf_bubbles); end
    endtask
`endif

    initial begin
        Reset = 1'b1;
        idle_inputs();
        test_reset();
        test_stall();
        test_redirect();
        test_wrap();
        test_halt();
        test_boot_halt();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
